// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous-read
// instruction memory and presents {PC+4, instruction} to the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned IMEM_ADDR_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze_i,
    input  logic                   branch_taken_i,
    input  logic [31:0]            branch_address_i,
    output logic [IMEM_ADDR_W-1:0] imem_addr_o,
    output logic                   imem_en_o,
    input  logic [31:0]            imem_rdata_i,
    output logic [31:0]            pc_out_o,
    output logic [31:0]            instruction_out_o,
    output logic                   valid_out_o,
    output logic                   flush_out_o,
    output logic [31:0]            fetch_count_o
);

    localparam int unsigned WORD_W = 32;

    // FILL: no correct-path word on imem_rdata yet; RUN: one word per unfrozen cycle
    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e              state_q,       state_d;
    logic [WORD_W-1:0]   fetch_pc_q,    fetch_pc_d;
    logic [WORD_W-1:0]   resp_pc_q,     resp_pc_d;
    logic [WORD_W-1:0]   fetch_count_q, fetch_count_d;
    logic                unused_branch_lsbs;

    // State and PC registers; reset overrides freeze and redirect immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_FILL;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Next state: redirect beats freeze, freeze holds everything, otherwise advance
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        fetch_count_d = fetch_count_q;

        if (branch_taken_i) begin
            // the word already in flight is wrong-path, so drop back to FILL
            fetch_pc_d = {branch_address_i[WORD_W-1:2], 2'b00};
            resp_pc_d  = '0;
            state_d    = S_FILL;
        end else if (!freeze_i) begin
            resp_pc_d  = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + WORD_W'(4);
            state_d    = S_RUN;
        end

        // a delivered instruction is one that IF/ID actually latches
        if ((state_q == S_RUN) && !freeze_i && !branch_taken_i) begin
            fetch_count_d = fetch_count_q + WORD_W'(1);
        end
    end

    // Memory interface: holding the enable low during freeze keeps rdata stable
    always_comb begin
        imem_addr_o = fetch_pc_q[IMEM_ADDR_W+1:2];
        imem_en_o   = rst | ~freeze_i | branch_taken_i;
        flush_out_o = branch_taken_i;
    end

    // IF/ID payload: a bubble presents NOP with a zero PC
    always_comb begin
        valid_out_o       = (state_q == S_RUN);
        pc_out_o          = '0;
        instruction_out_o = '0;
        if (state_q == S_RUN) begin
            pc_out_o          = resp_pc_q + WORD_W'(4);
            instruction_out_o = imem_rdata_i;
        end
        fetch_count_o = fetch_count_q;
    end

    // target is word aligned, so the byte offset bits are deliberately dropped
    assign unused_branch_lsbs = ^branch_address_i[1:0];

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: scoreboard for the delivered-instruction stream of
// a RESET_PC=0 instance, directed checks for freeze/redirect/reset, and a
// second instance with RESET_PC near the top of the address space.
`timescale 1ns/1ps
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        freeze, branch_taken;
    logic [31:0] branch_address;

    logic [9:0]  imem_addr_a, imem_addr_b;
    logic        imem_en_a, imem_en_b;
    logic [31:0] imem_rdata_a, imem_rdata_b;
    logic [31:0] pc_a, pc_b, instr_a, instr_b, count_a, count_b;
    logic        valid_a, valid_b, flush_a, flush_b;

    logic [31:0] mem [0:1023];

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_ADDR_W(10)) dut_a (
        .clk(clk), .rst(rst_a), .freeze_i(freeze), .branch_taken_i(branch_taken),
        .branch_address_i(branch_address), .imem_addr_o(imem_addr_a),
        .imem_en_o(imem_en_a), .imem_rdata_i(imem_rdata_a), .pc_out_o(pc_a),
        .instruction_out_o(instr_a), .valid_out_o(valid_a), .flush_out_o(flush_a),
        .fetch_count_o(count_a)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .IMEM_ADDR_W(10)) dut_b (
        .clk(clk), .rst(rst_b), .freeze_i(freeze), .branch_taken_i(branch_taken),
        .branch_address_i(branch_address), .imem_addr_o(imem_addr_b),
        .imem_en_o(imem_en_b), .imem_rdata_i(imem_rdata_b), .pc_out_o(pc_b),
        .instruction_out_o(instr_b), .valid_out_o(valid_b), .flush_out_o(flush_b),
        .fetch_count_o(count_b)
    );

    // synchronous-read memories, one per instance, holding rdata when disabled
    always @(posedge clk) begin
        if (imem_en_a) imem_rdata_a <= mem[imem_addr_a];
        if (imem_en_b) imem_rdata_b <= mem[imem_addr_b];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // one cycle of stimulus; accepted items go to the scoreboard queue
    task automatic step(input logic f, input logic b, input logic [31:0] ba,
                        input logic acc, input logic [31:0] epc, input logic [31:0] ein);
        @(negedge clk);
        freeze         = f;
        branch_taken   = b;
        branch_address = ba;
        if (acc) exp_q.push_back({epc, ein});
        #2;
    endtask

    // monitor: compares every instruction the IF/ID register latches
    always @(negedge clk) begin
        #1;
        if (!rst_a && valid_a && !freeze && !branch_taken) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL stream_unexpected: got pc %h instr %h, required none", pc_a, instr_a);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("stream_pc", pc_a, e[63:32]);
                chk("stream_instr", instr_a, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = 32'(k) + 32'h100;
        rst_a = 1'b1; rst_b = 1'b1;
        freeze = 1'b0; branch_taken = 1'b0; branch_address = '0;

        // reset state
        repeat (2) @(negedge clk);
        #2;
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_pc", pc_a, 32'd0);
        chk("rst_instr", instr_a, 32'd0);
        chk("rst_count", count_a, 32'd0);
        chk("rst_imem_en", 32'(imem_en_a), 32'd1);
        chk("rst_imem_addr", 32'(imem_addr_a), 32'd0);

        // release: one bubble, then a straight-line stream
        @(negedge clk); rst_a = 1'b0; #2;
        chk("fill_valid", 32'(valid_a), 32'd0);
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 32'(4 * i), 32'h0FF + 32'(i));

        // freeze three cycles at pc_out=20
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
            chk("frz_pc", pc_a, 32'd20);
            chk("frz_instr", instr_a, 32'h104);
            chk("frz_imem_en", 32'(imem_en_a), 32'd0);
            chk("frz_count", count_a, 32'd4);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'd20, 32'h104);

        // redirect to 0x43 (aligned to 0x40)
        step(1'b0, 1'b1, 32'h43, 1'b0, 32'h0, 32'h0);
        chk("br_flush", 32'(flush_a), 32'd1);
        chk("br_imem_en", 32'(imem_en_a), 32'd1);
        chk("br_count", count_a, 32'd5);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("br_bubble_valid", 32'(valid_a), 32'd0);
        chk("br_bubble_pc", pc_a, 32'd0);
        chk("br_bubble_instr", instr_a, 32'd0);
        chk("br_flush_low", 32'(flush_a), 32'd0);
        chk("br_imem_addr", 32'(imem_addr_a), 32'h10);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h44, 32'h110);

        // redirect together with freeze: redirect wins
        step(1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 32'h0);
        chk("brf_imem_en", 32'(imem_en_a), 32'd1);
        chk("brf_flush", 32'(flush_a), 32'd1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("brf_bubble_valid", 32'(valid_a), 32'd0);
        chk("brf_bubble_pc", pc_a, 32'd0);
        chk("brf_bubble_instr", instr_a, 32'd0);
        chk("brf_imem_addr", 32'(imem_addr_a), 32'h20);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h84, 32'h120);

        // reset asserted mid-freeze, between clock edges
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("frz2_pc", pc_a, 32'h88);
        chk("frz2_count", count_a, 32'd7);
        #1; rst_a = 1'b1; #1;
        chk("midrst_valid", 32'(valid_a), 32'd0);
        chk("midrst_pc", pc_a, 32'd0);
        chk("midrst_instr", instr_a, 32'd0);
        chk("midrst_count", count_a, 32'd0);
        chk("midrst_imem_addr", 32'(imem_addr_a), 32'd0);
        @(negedge clk); freeze = 1'b0; rst_a = 1'b0; #2;
        chk("refill_valid", 32'(valid_a), 32'd0);
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 32'(4 * i), 32'h0FF + 32'(i));
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'd20, 32'h104);
        chk("refill_count", count_a, 32'd4);
        @(negedge clk); rst_a = 1'b1;

        // second instance: address wrap at the top of memory
        @(negedge clk); rst_b = 1'b0; #2;
        chk("wrap_fill_valid", 32'(valid_b), 32'd0);
        chk("wrap_addr0", 32'(imem_addr_b), 32'h3FE);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("wrap_pc1", pc_b, 32'hFFFF_FFFC);
        chk("wrap_instr1", instr_b, 32'h4FE);
        chk("wrap_addr1", 32'(imem_addr_b), 32'h3FF);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("wrap_pc2", pc_b, 32'h0);
        chk("wrap_instr2", instr_b, 32'h4FF);
        chk("wrap_addr2", 32'(imem_addr_b), 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("wrap_pc3", pc_b, 32'h4);
        chk("wrap_instr3", instr_b, 32'h100);
        chk("wrap_count", count_b, 32'd2);

        repeat (2) @(negedge clk);
        #3;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
